// File: rtl/bus_pkg.sv
// Shared definitions for bus_responder: FSM states, MMIO map and the address decoder.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    REGION_RAM      = 3'd0,
    REGION_SCRATCH  = 3'd1,
    REGION_STATUS   = 3'd2,
    REGION_CTR      = 3'd3,
    REGION_UNMAPPED = 3'd4
  } region_t;

  localparam logic [16:0] CTR_BASE       = 17'h10000;
  localparam logic [16:0] SCRATCH_ADDR   = 17'h10008;
  localparam logic [16:0] STATUS_ADDR    = 17'h10009;
  localparam logic [7:0]  UNMAPPED_RDATA = 8'hFF;

  // The counter window only decodes when the counter is built in.
  function automatic region_t decode_addr(input logic [16:0] addr, input logic ctr_en);
    if (!addr[16])                                  return REGION_RAM;
    if (addr == SCRATCH_ADDR)                       return REGION_SCRATCH;
    if (addr == STATUS_ADDR)                        return REGION_STATUS;
    if (ctr_en && (addr[16:3] == CTR_BASE[16:3]))   return REGION_CTR;
    return REGION_UNMAPPED;
  endfunction

endpackage

// File: rtl/bus_ram.sv
// Single-port byte RAM with one-cycle synchronous read; contents are never reset.
module bus_ram #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/bus_responder.sv
// Byte-wide bus target: RAM plus scratch/status MMIO, three-cycle request/ack handshake.
// Optional 64-bit cycle counter at CTR_BASE when BUS_RESPONDER_CYCLE_CTR_EN is defined.
module bus_responder
  import bus_pkg::*;
#(
  parameter int MEM_DEPTH = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [16:0] bus_addr,
  input  logic [7:0]  bus_wdata,
  output logic [7:0]  bus_rdata,
  output logic        bus_ack
);

  localparam int AW = $clog2(MEM_DEPTH);
`ifdef BUS_RESPONDER_CYCLE_CTR_EN
  localparam logic CTR_EN = 1'b1;
`else
  localparam logic CTR_EN = 1'b0;
`endif

  state_t      state, next_state;
  logic        we_q;
  logic [16:0] addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  mmio_rdata_q;
  logic [7:0]  mmio_next;
  logic [7:0]  scratch_q;
  logic        err_sticky;
  logic [7:0]  ram_rdata;
  logic        ram_we;
  region_t     region;

  assign region = decode_addr(addr_q, CTR_EN);

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (bus_req) next_state = ST_ACCESS;
      ST_ACCESS:  next_state = ST_RESPOND;
      ST_RESPOND: next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    bus_ack   = (state == ST_RESPOND);
    bus_rdata = 8'h00;
    if (state == ST_RESPOND && !we_q)
      bus_rdata = (region == REGION_RAM) ? ram_rdata : mmio_rdata_q;
  end

  // Gating with reset suppresses a write whose commit edge lands inside reset.
  assign ram_we = (state == ST_ACCESS) && we_q && (region == REGION_RAM) && reset;

  bus_ram #(.DEPTH(MEM_DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (addr_q[AW-1:0]),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

`ifdef BUS_RESPONDER_CYCLE_CTR_EN
  logic [63:0] ctr_q;
  logic [63:0] snap_q;

  // Reading byte 0 freezes the whole count so bytes 1..7 stay consistent with it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctr_q  <= 64'd0;
      snap_q <= 64'd0;
    end else begin
      ctr_q <= ctr_q + 64'd1;
      if (state == ST_ACCESS && !we_q && region == REGION_CTR && addr_q[2:0] == 3'd0)
        snap_q <= ctr_q;
    end
  end
`endif

  always_comb begin
    mmio_next = 8'h00;
    case (region)
      REGION_SCRATCH:  mmio_next = scratch_q;
      REGION_STATUS:   mmio_next = {7'b0, err_sticky};
`ifdef BUS_RESPONDER_CYCLE_CTR_EN
      REGION_CTR:      mmio_next = (addr_q[2:0] == 3'd0) ? ctr_q[7:0]
                                                          : snap_q[{addr_q[2:0], 3'b000} +: 8];
`endif
      REGION_UNMAPPED: mmio_next = UNMAPPED_RDATA;
      default:         mmio_next = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      we_q         <= 1'b0;
      addr_q       <= 17'd0;
      wdata_q      <= 8'h00;
      mmio_rdata_q <= 8'h00;
      scratch_q    <= 8'h00;
      err_sticky   <= 1'b0;
    end else begin
      if (state == ST_IDLE && bus_req) begin
        we_q    <= bus_we;
        addr_q  <= bus_addr;
        wdata_q <= bus_wdata;
      end
      if (state == ST_ACCESS) begin
        if (!we_q) mmio_rdata_q <= mmio_next;
        if (we_q && region == REGION_SCRATCH) scratch_q <= wdata_q;
        // Status read returns the pre-clear value already captured above.
        if (region == REGION_UNMAPPED)
          err_sticky <= 1'b1;
        else if (region == REGION_STATUS && !we_q)
          err_sticky <= 1'b0;
      end
    end
  end

endmodule
